// File: rtl/acc_write_seq_pkg.sv
// Shared types for the accumulator write sequencer: FSM states and the
// delay-line entry that carries one row's write controls.
package acc_write_seq_pkg;

  // Entry address field is sized for the widest supported accumulator.
  localparam int ACC_ADDR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } acc_seq_state_e;

  typedef struct packed {
    logic                    valid;
    logic [ACC_ADDR_MAX-1:0] addr;
    logic                    accumulate;
  } acc_wr_entry_t;

endpackage

// File: rtl/acc_write_seq_delay_line.sv
// Generic fixed-depth shift register; advances only on enable, synchronous
// active-low clear of every stage.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (enable) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/acc_write_seq.sv
// Accumulator write sequencer: issues one row per enabled cycle and replays
// each row's address/flag through a LATENCY-deep line to the write port.
//
// Handshake: an instruction transfers on a clock edge where instr_valid,
// instr_ready and enable are all high; instr_* are ignored otherwise.
module acc_write_seq
  import acc_write_seq_pkg::*;
#(
  parameter int MATRIX_WIDTH   = 14,
  parameter int ACC_ADDR_WIDTH = 16,
  parameter int LENGTH_WIDTH   = 32,
  parameter int LATENCY        = 2*MATRIX_WIDTH+2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [LENGTH_WIDTH-1:0]   instr_length,
  input  logic                      instr_accumulate,
  output logic                      row_issue,
  output logic                      acc_wr_en,
  output logic [ACC_ADDR_WIDTH-1:0] acc_wr_addr,
  output logic                      acc_accumulate,
  output logic                      busy,
  output logic                      done,
  output acc_seq_state_e            dbg_state
);

  localparam int CNT_W = $clog2(LATENCY+1);

  acc_seq_state_e            state;
  logic [ACC_ADDR_WIDTH-1:0] addr_ctr;
  logic [LENGTH_WIDTH-1:0]   remaining;
  logic                      acc_flag;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          inflight_nxt;
  acc_wr_entry_t             push_entry;
  acc_wr_entry_t             head;

  // Idle slots push an all-zero entry so the write address reads 0 when unused.
  always_comb begin
    push_entry = '0;
    if (state == ISSUE) begin
      push_entry.valid      = 1'b1;
      push_entry.addr       = ACC_ADDR_MAX'(addr_ctr);
      push_entry.accumulate = acc_flag;
    end
  end

  always_comb begin
    inflight_nxt = inflight;
    case ({push_entry.valid, head.valid})
      2'b10:   inflight_nxt = inflight + CNT_W'(1);
      2'b01:   inflight_nxt = inflight - CNT_W'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_ctr  <= '0;
      remaining <= '0;
      acc_flag  <= 1'b0;
      inflight  <= '0;
      done      <= 1'b0;
    end else if (enable) begin
      inflight <= inflight_nxt;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            addr_ctr  <= instr_acc_addr;
            remaining <= instr_length;
            acc_flag  <= instr_accumulate;
            state     <= (instr_length == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          addr_ctr  <= addr_ctr + ACC_ADDR_WIDTH'(1);
          remaining <= remaining - LENGTH_WIDTH'(1);
          if (remaining == LENGTH_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // done is held for exactly one enabled cycle before returning idle.
          if (done) state <= IDLE;
          else if (inflight_nxt == '0) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  delay_line #(
    .WIDTH($bits(acc_wr_entry_t)),
    .DEPTH(LATENCY)
  ) u_delay_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .din    (push_entry),
    .dout   (head)
  );

  generate
    if (ACC_ADDR_WIDTH < ACC_ADDR_MAX) begin : g_addr_pad
      logic unused_head_addr;
      assign unused_head_addr = ^head.addr[ACC_ADDR_MAX-1:ACC_ADDR_WIDTH];
    end
  endgenerate

  assign instr_ready    = (state == IDLE);
  assign busy           = (state != IDLE);
  assign row_issue      = (state == ISSUE);
  assign acc_wr_en      = head.valid;
  assign acc_wr_addr    = head.addr[ACC_ADDR_WIDTH-1:0];
  assign acc_accumulate = head.accumulate;
  assign dbg_state      = state;

endmodule

// File: tb/tb_acc_write_seq.sv
// Directed bench for acc_write_seq with a schedule-based reference model,
// an expected-write queue and literal timing expectations.
module tb_acc_write_seq;

  localparam int MW  = 4;
  localparam int AW  = 16;
  localparam int LW  = 32;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_acc_addr;
  logic [LW-1:0] instr_length;
  logic          instr_accumulate;
  logic          row_issue;
  logic          acc_wr_en;
  logic [AW-1:0] acc_wr_addr;
  logic          acc_accumulate;
  logic          busy;
  logic          done;
  acc_write_seq_pkg::acc_seq_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;
  logic [AW:0] exp_q[$];
  logic [AW:0] exp_e;

  // Model: outputs are a function of enabled-edge count since acceptance.
  int            n_en = 0;
  bit            m_active = 1'b0;
  int            m_acc_n = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_len = 0;
  bit            m_flag = 1'b0;
  logic          cur_ready;
  logic          x_issue, x_wr, x_acc, x_busy, x_done;
  logic [AW-1:0] x_addr;

  acc_write_seq #(
    .MATRIX_WIDTH(MW), .ACC_ADDR_WIDTH(AW), .LENGTH_WIDTH(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_acc_addr(instr_acc_addr), .instr_length(instr_length),
    .instr_accumulate(instr_accumulate),
    .row_issue(row_issue), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_accumulate(acc_accumulate), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_outputs(output logic e_ready, output logic e_issue,
                                        output logic e_wr, output logic [AW-1:0] e_addr,
                                        output logic e_acc, output logic e_busy,
                                        output logic e_done);
    int c;
    int done_c;
    e_ready = 1'b1; e_issue = 1'b0; e_wr = 1'b0; e_addr = '0;
    e_acc = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      c = n_en - m_acc_n + 1;
      done_c = (m_len == 0) ? 2 : m_len + LAT + 1;
      if (c <= done_c) begin
        e_ready = 1'b0;
        e_busy  = 1'b1;
        e_issue = (c >= 1 && c <= m_len);
        if (c >= LAT + 1 && c <= m_len + LAT) begin
          e_wr   = 1'b1;
          e_addr = m_addr + AW'(c - LAT - 1);
          e_acc  = m_flag;
        end
        e_done = (c == done_c);
      end
    end
  endfunction

  always @(posedge clk) begin
    model_outputs(cur_ready, x_issue, x_wr, x_addr, x_acc, x_busy, x_done);
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (enable) begin
      n_en++;
      if (cur_ready && instr_valid) begin
        m_active = 1'b1;
        m_acc_n  = n_en;
        m_addr   = instr_acc_addr;
        m_len    = int'(instr_length);
        m_flag   = instr_accumulate;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic e_ready, e_issue, e_wr, e_acc, e_busy, e_done;
    logic [AW-1:0] e_addr;
    if (check_en) begin
      model_outputs(e_ready, e_issue, e_wr, e_addr, e_acc, e_busy, e_done);
      chk("instr_ready", 64'(instr_ready), 64'(e_ready));
      chk("row_issue", 64'(row_issue), 64'(e_issue));
      chk("acc_wr_en", 64'(acc_wr_en), 64'(e_wr));
      chk("acc_wr_addr", 64'(acc_wr_addr), 64'(e_addr));
      chk("acc_accumulate", 64'(acc_accumulate), 64'(e_acc));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
    end
  end

  // Scoreboard of write {accumulate, addr} in order
  always @(negedge clk) begin
    if (check_en && acc_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=%0h required=none @%0t", acc_wr_addr, $time);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_seq", 64'({acc_accumulate, acc_wr_addr}), 64'(exp_e));
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic acc);
    instr_valid      = 1'b1;
    instr_acc_addr   = a;
    instr_length     = len;
    instr_accumulate = acc;
    for (int i = 0; i < int'(len); i++) exp_q.push_back({acc, a + AW'(i)});
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic observe(input int start_c, input int ncyc,
                         output int f_iss, output int l_iss, output int f_wr,
                         output int l_wr, output int d_at, output int r_at);
    int c;
    f_iss = 0; l_iss = 0; f_wr = 0; l_wr = 0; d_at = 0; r_at = 0;
    for (int i = 0; i < ncyc; i++) begin
      c = start_c + i;
      if (row_issue === 1'b1) begin if (f_iss == 0) f_iss = c; l_iss = c; end
      if (acc_wr_en === 1'b1) begin if (f_wr == 0) f_wr = c; l_wr = c; end
      if (done === 1'b1 && d_at == 0) d_at = c;
      if (instr_ready === 1'b1 && r_at == 0) r_at = c;
      if (i < ncyc - 1) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int fi, li, fw, lw, da, ra;
    int c;
    enable = 1'b1; instr_valid = 1'b0;
    instr_acc_addr = '0; instr_length = '0; instr_accumulate = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("reset_ready", 64'(instr_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wr_en", 64'(acc_wr_en), 64'd0);
    chk("reset_issue", 64'(row_issue), 64'd0);
    @(negedge clk);

    // Basic: 0x10, three rows, accumulate
    send(16'h0010, 32'd3, 1'b1);
    observe(1, 16, fi, li, fw, lw, da, ra);
    chk("basic_first_issue", 64'(fi), 64'd1);
    chk("basic_last_issue", 64'(li), 64'd3);
    chk("basic_first_wr", 64'(fw), 64'd11);
    chk("basic_last_wr", 64'(lw), 64'd13);
    chk("basic_done", 64'(da), 64'd14);
    chk("basic_ready", 64'(ra), 64'd15);

    // Zero length
    send(16'h0030, 32'd0, 1'b1);
    observe(1, 4, fi, li, fw, lw, da, ra);
    chk("zero_issue", 64'(fi), 64'd0);
    chk("zero_wr", 64'(fw), 64'd0);
    chk("zero_done", 64'(da), 64'd2);
    chk("zero_ready", 64'(ra), 64'd3);

    // Address wrap
    send(16'hFFFE, 32'd4, 1'b1);
    observe(1, 17, fi, li, fw, lw, da, ra);
    chk("wrap_first_wr", 64'(fw), 64'd11);
    chk("wrap_last_wr", 64'(lw), 64'd14);
    chk("wrap_done", 64'(da), 64'd15);

    // Stall of 5 cycles between the two issues
    send(16'h0050, 32'd2, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    observe(7, 14, fi, li, fw, lw, da, ra);
    chk("stall_issue_held", 64'(li), 64'd7);
    chk("stall_first_wr", 64'(fw), 64'd16);
    chk("stall_last_wr", 64'(lw), 64'd17);
    chk("stall_done", 64'(da), 64'd18);
    chk("stall_ready", 64'(ra), 64'd19);

    // Reset after the 4th issue of an 8-row instruction
    send(16'h0060, 32'd8, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_issue", 64'(row_issue), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    observe(6, 15, fi, li, fw, lw, da, ra);
    chk("rst_no_stale_wr", 64'(fw), 64'd0);
    chk("rst_no_done", 64'(da), 64'd0);
    send(16'h0020, 32'd1, 1'b1);
    observe(1, 14, fi, li, fw, lw, da, ra);
    chk("post_rst_wr", 64'(fw), 64'd11);
    chk("post_rst_last_wr", 64'(lw), 64'd11);
    chk("post_rst_done", 64'(da), 64'd12);

    // Back-to-back with instr_valid held high
    instr_valid = 1'b1; instr_acc_addr = 16'h0070;
    instr_length = 32'd2; instr_accumulate = 1'b1;
    exp_q.push_back({1'b1, 16'h0070});
    exp_q.push_back({1'b1, 16'h0071});
    @(negedge clk);
    instr_acc_addr = 16'h0040; instr_length = 32'd2; instr_accumulate = 1'b0;
    exp_q.push_back({1'b0, 16'h0040});
    exp_q.push_back({1'b0, 16'h0041});
    c = 1; da = 0; ra = 0;
    while (c < 40 && ra == 0) begin
      if (done === 1'b1 && da == 0) da = c;
      if (instr_ready === 1'b1) ra = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("b2b_first_done", 64'(da), 64'd13);
    chk("b2b_ready", 64'(ra), 64'd14);
    @(negedge clk);
    instr_valid = 1'b0;
    observe(1, 14, fi, li, fw, lw, da, ra);
    chk("b2b_issue_first", 64'(fi), 64'd1);
    chk("b2b_issue_last", 64'(li), 64'd2);
    chk("b2b_first_wr", 64'(fw), 64'd11);
    chk("b2b_last_wr", 64'(lw), 64'd12);
    chk("b2b_done", 64'(da), 64'd13);
    chk("b2b_ready2", 64'(ra), 64'd14);

    @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_write_seq.md
Name: acc_write_seq

Overview:
- Sequencer directly upstream of the accumulator write port, which is also where the accumulator address counter sits.
- Accepts one matrix-multiply instruction per handshake: base accumulator address, row count, and accumulate/overwrite flag.
- Issues one row per enabled cycle into the systolic array.
- Replays each row's accumulator address and accumulate flag through a fixed-latency delay line, so write controls line up with the array's result rows.

Parameters:
- MATRIX_WIDTH, 14, systolic array dimension; sets default latency.
- ACC_ADDR_WIDTH, 16, accumulator address width.
- LENGTH_WIDTH, 32, row-count width.
- LATENCY, 2*MATRIX_WIDTH+2, cycles from row issue to result row at accumulator; must be ≥1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  global advance; low freezes all state, including the delay line.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_acc_addr  input  ACC_ADDR_WIDTH  first accumulator row address.
- instr_length  input  LENGTH_WIDTH  number of rows.
- instr_accumulate  input  1  1 = add to accumulator, 0 = overwrite.
- row_issue  output  1  a row enters the array this cycle.
- acc_wr_en  output  1  write result row this cycle.
- acc_wr_addr  output  ACC_ADDR_WIDTH  accumulator row address.
- acc_accumulate  output  1  accumulate flag for this write.
- busy  output  1  instruction in progress (ISSUE or DRAIN).
- done  output  1  one-cycle pulse when the last write has left the delay line.

Behaviour:
Reset (rst_n=0 at a clock edge):
- All outputs 0 except instr_ready=1.
- FSM goes to IDLE, delay line cleared, counters 0.
- Reset mid-operation drops all in-flight writes; no done pulse.

FSM states: IDLE, ISSUE, DRAIN.
- No state changes while enable=0, except reset.
- instr_ready = (state==IDLE).
- IDLE: on instr_valid & instr_ready & enable, latch addr, length and flag.
  - If length==0: go to DRAIN. Delay line is empty, so done pulses the next enabled cycle and the FSM returns to IDLE. No writes occur.
  - Otherwise go to ISSUE.
- ISSUE, each enabled cycle:
  - row_issue=1.
  - Push {valid=1, addr_ctr, flag} into the delay line.
  - addr_ctr += 1, wrapping modulo 2^ACC_ADDR_WIDTH.
  - remaining -= 1.
  - When remaining reaches 0 after the push, go to DRAIN.
  - First issue is the cycle after acceptance.
- DRAIN: push {valid=0} each enabled cycle. When in-flight count==0, assert done for 1 cycle and go to IDLE. A new instruction is accepted from the cycle after done, so there is no overlap between instructions.

Delay line and in-flight count:
- Delay line is LATENCY stages, shifting only when enable=1.
- acc_wr_en/acc_wr_addr/acc_accumulate are the registered head entry.
- A row issued in enabled cycle t appears at the outputs after exactly LATENCY enabled cycles.
- In-flight counter: +1 on push-valid, −1 on output-valid; both in the same cycle leaves it unchanged.
- Its width is clog2(LATENCY+1).

Width and edge rules:
- Address arithmetic is unsigned, and wrap is legal.
- length up to 2^LENGTH_WIDTH−1.
- acc_wr_addr is only meaningful while acc_wr_en=1; it holds 0 otherwise.
- busy = (state!=IDLE).
- instr_* are ignored while instr_ready=0.

Decomposition:
- Shared package: acc_wr_entry_t typedef (valid, addr, accumulate) and the ACC_SEQ_STATE enum (IDLE/ISSUE/DRAIN).
- Sub-module: delay_line, a generic parameterised-width/depth shift register with enable and synchronous active-low clear, reused for acc_wr_entry_t.

Test Plan:
- Basic, MATRIX_WIDTH=4, LATENCY=10: instr addr=0x0010, length=3, accumulate=1.
  - row_issue high for cycles 1–3 after accept.
  - acc_wr_en high for cycles 11–13 with addr 0x10, 0x11, 0x12 and acc_accumulate=1.
  - done pulses at cycle 14; instr_ready=1 at cycle 15.
- Zero length: length=0 → no row_issue, no acc_wr_en; done pulses 2 cycles after accept.
- Wrap: ACC_ADDR_WIDTH=16, addr=0xFFFE, length=4 → write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Stall: length=2; hold enable=0 for 5 cycles between the two issues.
  - Writes arrive LATENCY enabled cycles after each issue.
  - No outputs change during the stall.
  - done is delayed by exactly 5 cycles.
- Reset mid-flight: length=8, assert rst_n=0 for one cycle after the 4th issue.
  - All outputs 0, instr_ready=1 next cycle.
  - No stale acc_wr_en ever appears.
  - A following instr (addr=0x20, length=1) writes only 0x20.
- Back-to-back: instr_valid held high with a second instr (overwrite, addr=0x40, length=2).
  - Second is accepted only in the cycle after the first done.
  - Its writes carry acc_accumulate=0.
